// File: rtl/register_file_ext.sv
// Integer register file with configurable read ports, write-to-read bypass and a
// per-register pending scoreboard; contents are zeroed one entry per cycle after reset.
module register_file_ext #(
    parameter  int XLEN     = 32,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_READ = 2,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic [NUM_READ*AW-1:0]   read_address,
    output logic [NUM_READ*XLEN-1:0] read_data,
    output logic [NUM_READ-1:0]      read_pending,
    input  logic [AW-1:0]            write_address,
    input  logic [XLEN-1:0]          write_data,
    input  logic                     write_enable,
    input  logic [AW-1:0]            reserve_address,
    input  logic                     reserve_enable
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [AW-1:0]       cnt;
    logic [AW-1:0]       cnt_next;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;

    logic [XLEN-1:0]     file [NUM_REGS];
    logic                file_we;
    logic [AW-1:0]       file_wa;
    logic [XLEN-1:0]     file_wd;

    // ready is a plain level, not a handshake: once high, the file accepts
    // writes/reserves every cycle and reads return architectural values,
    // until the next reset drops it.
    assign ready = (state == RUN);

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pending_next = pending;
        file_we      = 1'b0;
        file_wa      = '0;
        file_wd      = '0;
        case (state)
            CLEAR: begin
                file_we  = 1'b1;
                file_wa  = cnt;
                cnt_next = cnt + AW'(1);
                if (cnt == AW'(NUM_REGS - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (write_enable && (write_address != '0)) begin
                    file_we                     = 1'b1;
                    file_wa                     = write_address;
                    file_wd                     = write_data;
                    pending_next[write_address] = 1'b0;
                end
                // Applied after the write so a same-cycle reserve leaves the bit set.
                if (reserve_enable && (reserve_address != '0)) begin
                    pending_next[reserve_address] = 1'b1;
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= CLEAR;
            cnt     <= '0;
            pending <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pending <= pending_next;
        end
    end

    // No reset on the array itself so it maps onto RAM; the clear walk zeroes it.
    always_ff @(posedge clk) begin
        if (rst && file_we) begin
            file[file_wa] <= file_wd;
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_read
        logic [AW-1:0] ra;
        logic          hit;
        assign ra  = read_address[g*AW +: AW];
        assign hit = (BYPASS != 0) && write_enable && (write_address != '0)
                     && (write_address == ra);
        assign read_data[g*XLEN +: XLEN] = (state == CLEAR) ? '0 :
                                           hit ? write_data : file[ra];
        assign read_pending[g]           = (state == CLEAR) ? 1'b0 :
                                           hit ? 1'b0 : pending[ra];
    end

endmodule

// File: tb/tb_register_file_ext.sv
// Directed bench for register_file_ext: default build, a no-bypass build and a
// 64-bit / 16-entry / 3-port build driven with random traffic against a model.
module tb_register_file_ext;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // default build
    logic        rst_a, ready_a, we_a, se_a;
    logic [9:0]  ra_a;
    logic [63:0] rd_a;
    logic [1:0]  rp_a;
    logic [4:0]  wa_a, sa_a;
    logic [31:0] wd_a;

    // BYPASS=0 build
    logic        rst_b, ready_b, we_b, se_b;
    logic [9:0]  ra_b;
    logic [63:0] rd_b;
    logic [1:0]  rp_b;
    logic [4:0]  wa_b, sa_b;
    logic [31:0] wd_b;

    // XLEN=64, NUM_REGS=16, NUM_READ=3 build
    logic         rst_c, ready_c, we_c, se_c;
    logic [11:0]  ra_c;
    logic [191:0] rd_c;
    logic [2:0]   rp_c;
    logic [3:0]   wa_c, sa_c;
    logic [63:0]  wd_c;

    register_file_ext u_dut_a (
        .clk(clk), .rst(rst_a), .ready(ready_a),
        .read_address(ra_a), .read_data(rd_a), .read_pending(rp_a),
        .write_address(wa_a), .write_data(wd_a), .write_enable(we_a),
        .reserve_address(sa_a), .reserve_enable(se_a)
    );

    register_file_ext #(.BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst_b), .ready(ready_b),
        .read_address(ra_b), .read_data(rd_b), .read_pending(rp_b),
        .write_address(wa_b), .write_data(wd_b), .write_enable(we_b),
        .reserve_address(sa_b), .reserve_enable(se_b)
    );

    register_file_ext #(.XLEN(64), .NUM_REGS(16), .NUM_READ(3)) u_dut_c (
        .clk(clk), .rst(rst_c), .ready(ready_c),
        .read_address(ra_c), .read_data(rd_c), .read_pending(rp_c),
        .write_address(wa_c), .write_data(wd_c), .write_enable(we_c),
        .reserve_address(sa_c), .reserve_enable(se_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [63:0] m_reg [16];
    logic        m_pend [16];
    logic [3:0]  a;
    logic [63:0] exp_d;
    logic        exp_p;
    int          edge_a, edge_c, edge_b;

    initial begin
        rst_a = 1'b0; we_a = 1'b0; se_a = 1'b0; ra_a = {5'd5, 5'd5}; wa_a = '0; sa_a = '0; wd_a = '0;
        rst_b = 1'b0; we_b = 1'b0; se_b = 1'b0; ra_b = '0; wa_b = '0; sa_b = '0; wd_b = '0;
        rst_c = 1'b0; we_c = 1'b0; se_c = 1'b0; ra_c = '0; wa_c = '0; sa_c = '0; wd_c = '0;

        // reset held for three edges
        tick(); tick(); tick();
        check("reset_ready", ready_a, 0);
        check("reset_rd", rd_a, 0);
        check("reset_rp", rp_a, 0);

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        edge_a = 0; edge_b = 0; edge_c = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (ready_a && edge_a == 0) edge_a = n;
            if (ready_b && edge_b == 0) edge_b = n;
            if (ready_c && edge_c == 0) edge_c = n;
            if (n == 10) begin
                check("clear_rd_forced", rd_a, 0);
                check("clear_rp_forced", rp_a, 0);
            end
        end
        check("ready_edge_a", edge_a, 32);
        check("ready_edge_b", edge_b, 32);
        check("ready_edge_c", edge_c, 16);

        // every register cleared and idle
        for (int i = 0; i < 32; i += 2) begin
            ra_a = {5'(i + 1), 5'(i)};
            #1;
            check($sformatf("cleared_rd_x%0d", i), rd_a, 0);
            check($sformatf("cleared_rp_x%0d", i), rp_a, 0);
        end

        // write with same-cycle bypass on both ports
        ra_a = {5'd5, 5'd5}; wa_a = 5'd5; wd_a = 32'hDEADBEEF; we_a = 1'b1;
        #1;
        check("bypass_x5_same", rd_a, {32'hDEADBEEF, 32'hDEADBEEF});
        tick(); we_a = 1'b0; #1;
        check("bypass_x5_after", rd_a, {32'hDEADBEEF, 32'hDEADBEEF});

        // x0 ignores writes
        ra_a = {5'd0, 5'd0}; wa_a = 5'd0; wd_a = 32'h1234; we_a = 1'b1;
        #1;
        check("x0_write_same", rd_a, 0);
        tick(); we_a = 1'b0; #1;
        check("x0_write_after", rd_a, 0);

        // scoreboard: reserve visible next cycle only
        ra_a = {5'd7, 5'd7}; sa_a = 5'd7; se_a = 1'b1;
        #1;
        check("reserve_same_cycle", rp_a, 2'b00);
        tick(); se_a = 1'b0; #1;
        check("reserve_next_cycle", rp_a, 2'b11);

        // writeback clears pending, bypassed in the same cycle
        wa_a = 5'd7; wd_a = 32'hA5; we_a = 1'b1;
        #1;
        check("wb_pend_same", rp_a, 2'b00);
        check("wb_data_same", rd_a, {32'hA5, 32'hA5});
        tick(); we_a = 1'b0; #1;
        check("wb_pend_after", rp_a, 2'b00);
        check("wb_data_after", rd_a, {32'hA5, 32'hA5});

        // reserve and write together: data lands, reserve wins
        wa_a = 5'd7; wd_a = 32'h77; we_a = 1'b1; sa_a = 5'd7; se_a = 1'b1;
        #1;
        check("collide_data_same", rd_a, {32'h77, 32'h77});
        tick(); we_a = 1'b0; se_a = 1'b0; #1;
        check("collide_pend_after", rp_a, 2'b11);
        check("collide_data_after", rd_a, {32'h77, 32'h77});

        // independent ports
        ra_a = {5'd5, 5'd7};
        #1;
        check("ports_rd", rd_a, {32'hDEADBEEF, 32'h77});
        check("ports_rp", rp_a, 2'b01);

        // no-bypass build: old value this cycle, new value next
        ra_b = {5'd3, 5'd3}; wa_b = 5'd3; wd_b = 32'h55; we_b = 1'b1;
        #1;
        check("nobyp_same", rd_b, 0);
        tick(); we_b = 1'b0; #1;
        check("nobyp_after", rd_b, {32'h55, 32'h55});
        sa_b = 5'd3; se_b = 1'b1;
        tick(); se_b = 1'b0; #1;
        check("nobyp_reserve", rp_b, 2'b11);
        wa_b = 5'd3; wd_b = 32'h66; we_b = 1'b1;
        #1;
        check("nobyp_pend_same", rp_b, 2'b11);
        check("nobyp_data_same", rd_b, {32'h55, 32'h55});
        tick(); we_b = 1'b0; #1;
        check("nobyp_pend_after", rp_b, 2'b00);
        check("nobyp_data_after", rd_b, {32'h66, 32'h66});

        // reset in RUN with x9 and x7 pending
        sa_a = 5'd9; se_a = 1'b1;
        tick(); se_a = 1'b0;
        ra_a = {5'd9, 5'd7};
        #1;
        check("run_pend_before_rst", rp_a, 2'b11);
        check("run_ready_before_rst", ready_a, 1);
        rst_a = 1'b0;
        tick();
        check("run_rst_ready", ready_a, 0);
        check("run_rst_rp", rp_a, 0);
        check("run_rst_rd", rd_a, 0);

        // reset in the middle of the clear walk restarts it
        rst_a = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        check("midclear_ready", ready_a, 0);
        rst_a = 1'b0;
        tick();
        check("midclear_rst_ready", ready_a, 0);
        rst_a = 1'b1;
        edge_a = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (ready_a && edge_a == 0) edge_a = n;
        end
        check("midclear_ready_edge", edge_a, 32);
        check("midclear_pend_clear", rp_a, 0);
        ra_a = {5'd5, 5'd7};
        #1;
        check("midclear_data_clear", rd_a, 0);

        // random traffic on the 3-port build against the model
        for (int i = 0; i < 16; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 200; cyc++) begin
            we_c = 1'($urandom_range(0, 1));
            wa_c = 4'($urandom_range(0, 15));
            wd_c = {$urandom, $urandom};
            se_c = 1'($urandom_range(0, 1));
            sa_c = 4'($urandom_range(0, 15));
            for (int p = 0; p < 3; p++) begin
                if (p == 2 && $urandom_range(0, 2) == 0) ra_c[p*4 +: 4] = wa_c;
                else ra_c[p*4 +: 4] = 4'($urandom_range(0, 15));
            end
            #1;
            for (int p = 0; p < 3; p++) begin
                a = ra_c[p*4 +: 4];
                if (we_c && wa_c != 0 && wa_c == a) begin
                    exp_d = wd_c;
                    exp_p = 1'b0;
                end else begin
                    exp_d = m_reg[a];
                    exp_p = m_pend[a];
                end
                check($sformatf("sweep_rd%0d_c%0d", p, cyc), rd_c[p*64 +: 64], exp_d);
                check($sformatf("sweep_rp%0d_c%0d", p, cyc), rp_c[p], exp_p);
            end
            if (we_c && wa_c != 0) begin
                m_reg[wa_c]  = wd_c;
                m_pend[wa_c] = 1'b0;
            end
            if (se_c && sa_c != 0) m_pend[sa_c] = 1'b1;
            tick();
        end
        we_c = 1'b0; se_c = 1'b0;
        #1;
        check("sweep_ready_held", ready_c, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
